// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: register specifiers and pipeline-control FSM states.
package lc3b_types;
  typedef logic [2:0] lc3b_reg;
  typedef enum logic [1:0] {RUN, WAIT_I, WAIT_D, WAIT_ID} pipe_ctrl_state_t;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: ID sources against a load's destination in EX.
module hazard_detect
  import lc3b_types::*;
(
  input  lc3b_reg    id_sr1,
  input  lc3b_reg    id_sr2,
  input  logic       id_sr1_used,
  input  logic       id_sr2_used,
  input  lc3b_reg    ex_dest,
  input  logic       ex_is_load,
  output logic       lu
);
  logic sr1_hit, sr2_hit;

  assign sr1_hit = id_sr1_used & (id_sr1 == ex_dest);
  assign sr2_hit = id_sr2_used & (id_sr2 == ex_dest);
  assign lu      = ex_is_load & (sr1_hit | sr2_hit);
endmodule

// File: rtl/pipeline_ctrl.sv
// LC-3b 5-stage pipeline control: cache wait-state freeze, load-use bubble,
// taken-branch squash and a saturating stall-cycle counter.
module pipeline_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             if_req,
  input  logic             imem_resp,
  output logic             imem_read,
  output logic             ir_capture,
  input  logic             mem_rd_req,
  input  logic             mem_wr_req,
  input  logic             dmem_resp,
  output logic             dmem_read,
  output logic             dmem_write,
  input  lc3b_reg          id_sr1,
  input  lc3b_reg          id_sr2,
  input  logic             id_sr1_used,
  input  logic             id_sr2_used,
  input  lc3b_reg          ex_dest,
  input  logic             ex_is_load,
  input  logic             mem_br_taken,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             pc_sel_target,
  output logic [CNT_W-1:0] stall_count
);
  pipe_ctrl_state_t state, state_next, pend_state;
  logic i_done, d_done;
  logic i_pend, d_pend, freeze, lu;

  assign i_pend = if_req & ~i_done & ~imem_resp;
  assign d_pend = (mem_rd_req | mem_wr_req) & ~d_done & ~dmem_resp;
  assign freeze = i_pend | d_pend;

  hazard_detect u_hazard (
    .id_sr1      (id_sr1),
    .id_sr2      (id_sr2),
    .id_sr1_used (id_sr1_used),
    .id_sr2_used (id_sr2_used),
    .ex_dest     (ex_dest),
    .ex_is_load  (ex_is_load),
    .lu          (lu)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  always_comb begin
    pend_state = RUN;
    if (i_pend && d_pend) pend_state = WAIT_ID;
    else if (i_pend)      pend_state = WAIT_I;
    else if (d_pend)      pend_state = WAIT_D;
  end

  // WAIT states only narrow as responses land; the pend terms already encode that.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:            state_next = pend_state;
      WAIT_ID:        state_next = pend_state;
      WAIT_I, WAIT_D: state_next = pend_state;
      default:        state_next = RUN;
    endcase
  end

  // A response that lands while the other side still waits is remembered so the
  // satisfied request is not re-issued for the rest of the freeze.
  always_ff @(posedge clk) begin
    if (!reset_n || !freeze) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      if (imem_resp && d_pend) i_done <= 1'b1;
      if (dmem_resp && i_pend) d_done <= 1'b1;
    end
  end

  always_comb begin
    imem_read     = 1'b0;
    ir_capture    = 1'b0;
    dmem_read     = 1'b0;
    dmem_write    = 1'b0;
    load_pc       = 1'b1;
    load_if_id    = 1'b1;
    load_id_ex    = 1'b1;
    load_ex_mem   = 1'b1;
    load_mem_wb   = 1'b1;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    pc_sel_target = 1'b0;
    if (!reset_n) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else begin
      imem_read  = if_req & ~i_done;
      dmem_read  = mem_rd_req & ~d_done;
      dmem_write = mem_wr_req & ~d_done;
      ir_capture = imem_resp & if_req & ~i_done;
      if (freeze) begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
      end else if (mem_br_taken) begin
        flush_if_id   = 1'b1;
        flush_id_ex   = 1'b1;
        flush_ex_mem  = 1'b1;
        pc_sel_target = 1'b1;
      end else if (lu) begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        flush_id_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      stall_count <= '0;
    else if (!load_pc && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl against a behavioural model of the control rules.
module tb_pipeline_ctrl;
  import lc3b_types::*;

  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n;
  logic if_req, imem_resp, mem_rd_req, mem_wr_req, dmem_resp;
  logic id_sr1_used, id_sr2_used, ex_is_load, mem_br_taken;
  lc3b_reg id_sr1, id_sr2, ex_dest;
  logic imem_read, ir_capture, dmem_read, dmem_write;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, pc_sel_target;
  logic [CNT_W-1:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  bit m_idone, m_ddone;
  int m_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .imem_resp(imem_resp), .imem_read(imem_read), .ir_capture(ir_capture),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .dmem_resp(dmem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .id_sr1(id_sr1), .id_sr2(id_sr2), .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
    .ex_dest(ex_dest), .ex_is_load(ex_is_load), .mem_br_taken(mem_br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .pc_sel_target(pc_sel_target), .stall_count(stall_count)
  );

  wire [12:0] obs = {imem_read, ir_capture, dmem_read, dmem_write,
                     load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                     flush_if_id, flush_id_ex, flush_ex_mem, pc_sel_target};

  function automatic bit m_ipend();
    return if_req && !m_idone && !imem_resp;
  endfunction
  function automatic bit m_dpend();
    return (mem_rd_req || mem_wr_req) && !m_ddone && !dmem_resp;
  endfunction
  function automatic bit m_lu();
    return ex_is_load && ((id_sr1_used && id_sr1 == ex_dest) || (id_sr2_used && id_sr2 == ex_dest));
  endfunction

  // Expected outputs straight from the control rules, in the same bit order as obs.
  function automatic logic [12:0] m_expect();
    bit fz, br, bubble, ird, drd, dwr, cap;
    if (!reset_n) return 13'b0000_11111_1110;
    fz     = m_ipend() || m_dpend();
    br     = !fz && mem_br_taken;
    bubble = !fz && !mem_br_taken && m_lu();
    ird    = if_req && !m_idone;
    drd    = mem_rd_req && !m_ddone;
    dwr    = mem_wr_req && !m_ddone;
    cap    = imem_resp && ird;
    return {ird, cap, drd, dwr,
            !(fz || bubble), !(fz || bubble), !fz, !fz, !fz,
            br, br || bubble, br, br};
  endfunction

  task automatic idle();
    if_req = 0; imem_resp = 0; mem_rd_req = 0; mem_wr_req = 0; dmem_resp = 0;
    id_sr1 = 0; id_sr2 = 0; id_sr1_used = 0; id_sr2_used = 0;
    ex_dest = 0; ex_is_load = 0; mem_br_taken = 0;
  endtask

  // One clock: check combinational outputs, take the edge, advance model, check counter.
  task automatic cycle(input string name);
    logic [12:0] exp;
    bit fz, ip, dp;
    #1;
    exp = m_expect();
    ip = m_ipend(); dp = m_dpend(); fz = ip || dp;
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s outputs: got %b want %b at %0t", name, obs, exp, $time);
    end
    @(posedge clk);
    if (!reset_n) begin
      m_idone = 0; m_ddone = 0; m_cnt = 0;
    end else begin
      if (!exp[8] && m_cnt < CNT_MAX) m_cnt++;
      if (!fz) begin
        m_idone = 0; m_ddone = 0;
      end else begin
        if (imem_resp && dp) m_idone = 1;
        if (dmem_resp && ip) m_ddone = 1;
      end
    end
    #1;
    n_cmp++;
    if (stall_count !== CNT_W'(m_cnt)) begin
      n_bad++;
      $display("FAIL %s stall_count: got %0d want %0d at %0t", name, stall_count, m_cnt, $time);
    end
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    cycle("reset");
    cycle("reset");
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) cycle("idle");
    n_cmp++;
    if (stall_count !== '0) begin
      n_bad++;
      $display("FAIL idle_count: got %0d want 0", stall_count);
    end
  endtask

  task automatic test_ifetch();
    int start = m_cnt;
    int caps = 0;
    idle();
    if_req = 1;
    for (int i = 0; i < 5; i++) begin
      imem_resp = (i == 4);
      #1;
      if (ir_capture) caps++;
      cycle("ifetch");
    end
    idle();
    n_cmp++;
    if (caps != 1 || int'(stall_count) - start != 4) begin
      n_bad++;
      $display("FAIL ifetch_summary: got caps=%0d stalls=%0d want caps=1 stalls=4",
               caps, int'(stall_count) - start);
    end
  endtask

  task automatic test_both();
    int start;
    do_reset();
    start = m_cnt;
    if_req = 1; mem_rd_req = 1;
    for (int i = 0; i < 6; i++) begin
      imem_resp = (i == 2);
      dmem_resp = (i == 5);
      cycle("both");
      if (i == 2) begin
        n_cmp++;
        if (dut.state !== WAIT_D || imem_read !== 1'b0) begin
          n_bad++;
          $display("FAIL both_wait_d: got state=%0d imem_read=%b want state=%0d imem_read=0",
                   dut.state, imem_read, WAIT_D);
        end
      end
    end
    idle();
    n_cmp++;
    if (int'(stall_count) - start != 5 || dut.state !== RUN) begin
      n_bad++;
      $display("FAIL both_summary: got stalls=%0d state=%0d want stalls=5 state=%0d",
               int'(stall_count) - start, dut.state, RUN);
    end
  endtask

  task automatic test_load_use();
    idle();
    ex_is_load = 1; ex_dest = 3; id_sr2 = 3; id_sr2_used = 1; id_sr1 = 5; id_sr1_used = 1;
    #1;
    n_cmp++;
    if ({load_pc, load_if_id, load_id_ex, flush_id_ex} !== 4'b0011) begin
      n_bad++;
      $display("FAIL load_use_bubble: got %b want 0011", {load_pc, load_if_id, load_id_ex, flush_id_ex});
    end
    cycle("load_use");
    idle();
    cycle("after_load_use");
    ex_is_load = 1; ex_dest = 6; id_sr1 = 6; id_sr1_used = 0; id_sr2 = 6; id_sr2_used = 0;
    cycle("load_use_unused");
    idle();
  endtask

  task automatic test_branch();
    idle();
    ex_is_load = 1; ex_dest = 2; id_sr1 = 2; id_sr1_used = 1; mem_br_taken = 1;
    #1;
    n_cmp++;
    if ({flush_if_id, flush_id_ex, flush_ex_mem, pc_sel_target, load_pc, load_if_id} !== 6'b111111) begin
      n_bad++;
      $display("FAIL branch_over_lu: got %b want 111111",
               {flush_if_id, flush_id_ex, flush_ex_mem, pc_sel_target, load_pc, load_if_id});
    end
    cycle("branch");
    // a branch under a pending D-cache access must wait for the freeze
    mem_wr_req = 1;
    cycle("branch_frozen");
    dmem_resp = 1;
    cycle("branch_release");
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset_n      = ($urandom_range(0, 39) != 0);
      if_req       = ($urandom_range(0, 2) != 0);
      imem_resp    = ($urandom_range(0, 2) == 0);
      mem_rd_req   = ($urandom_range(0, 3) == 0);
      mem_wr_req   = ($urandom_range(0, 4) == 0);
      dmem_resp    = ($urandom_range(0, 2) == 0);
      id_sr1       = lc3b_reg'($urandom_range(0, 7));
      id_sr2       = lc3b_reg'($urandom_range(0, 7));
      ex_dest      = lc3b_reg'($urandom_range(0, 7));
      id_sr1_used  = 1'($urandom);
      id_sr2_used  = 1'($urandom);
      ex_is_load   = 1'($urandom);
      mem_br_taken = ($urandom_range(0, 4) == 0);
      cycle("random");
    end
    idle();
    reset_n = 1;
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    if_req = 1;
    for (int i = 0; i < CNT_MAX + 4; i++) cycle("saturate");
    n_cmp++;
    if (stall_count !== {CNT_W{1'b1}}) begin
      n_bad++;
      $display("FAIL saturate: got %h want ffff", stall_count);
    end
    idle();
    cycle("drain");
    mem_wr_req = 1;
    cycle("enter_wait_d");
    cycle("wait_d");
    n_cmp++;
    if (dut.state !== WAIT_D) begin
      n_bad++;
      $display("FAIL wait_d_state: got %0d want %0d", dut.state, WAIT_D);
    end
    reset_n = 0;
    #1;
    n_cmp++;
    if (dmem_write !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_strobe: got dmem_write=%b want 0", dmem_write);
    end
    cycle("reset_mid_wait");
    n_cmp++;
    if (dut.state !== RUN || stall_count !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_wait: got state=%0d count=%0d want state=%0d count=0",
               dut.state, stall_count, RUN);
    end
    idle();
    reset_n = 1;
    cycle("post_reset_idle");
  endtask

  initial begin
    idle();
    reset_n = 0;
    m_idone = 0; m_ddone = 0; m_cnt = 0;
    test_reset();
    test_ifetch();
    test_both();
    test_load_use();
    test_branch();
    test_random();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
